// File: rtl/rr_arb_mux.sv
// Registered N:1 write-bus multiplexer with round-robin arbitration,
// a forced-select override and a single valid/ready output stage.

`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module rr_arb_mux #(
    parameter int unsigned DATAWIDTH = `DATAWIDTH,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned SELW      = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             in_valid,
    input  logic [NUM_CH*DATAWIDTH-1:0]   in_data,
    output logic [NUM_CH-1:0]             in_ready,
    input  logic                          force_en,
    input  logic [SELW-1:0]               force_sel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATAWIDTH-1:0]          out_data,
    output logic [SELW-1:0]               out_ch
);

    logic                 run;
    logic [SELW-1:0]      ptr;

    logic                 load_c;
    logic                 gnt_vld_c;
    logic [SELW-1:0]      gnt_idx_c;
    logic [DATAWIDTH-1:0] gnt_data_c;
    logic                 hi_vld_c;
    logic [SELW-1:0]      hi_idx_c;
    logic                 lo_vld_c;
    logic [SELW-1:0]      lo_idx_c;

    // Output stage can take a word when empty or draining this cycle.
    assign load_c = run & (~out_valid | out_ready);

    // Grant: forced channel, else first valid at/after ptr, else first valid overall (wrap).
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        hi_vld_c  = 1'b0;
        hi_idx_c  = '0;
        lo_vld_c  = 1'b0;
        lo_idx_c  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (in_valid[i]) begin
                if (!lo_vld_c) begin
                    lo_vld_c = 1'b1;
                    lo_idx_c = SELW'(i);
                end
                if (!hi_vld_c && (SELW'(i) >= ptr)) begin
                    hi_vld_c = 1'b1;
                    hi_idx_c = SELW'(i);
                end
            end
        end
        if (force_en) begin
            // Out-of-range force_sel never matches, so it yields no grant.
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if ((force_sel == SELW'(i)) && in_valid[i]) begin
                    gnt_vld_c = 1'b1;
                    gnt_idx_c = SELW'(i);
                end
            end
        end else if (hi_vld_c) begin
            gnt_vld_c = 1'b1;
            gnt_idx_c = hi_idx_c;
        end else if (lo_vld_c) begin
            gnt_vld_c = 1'b1;
            gnt_idx_c = lo_idx_c;
        end
    end

    // Select the granted channel's word.
    always_comb begin
        gnt_data_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt_idx_c == SELW'(i)) begin
                gnt_data_c = in_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // One-hot ready back to the granted source when the output stage can load.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            in_ready[i] = load_c & gnt_vld_c & (gnt_idx_c == SELW'(i));
        end
    end

    // Run flag holds off handshakes for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Output pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load_c) begin
            if (gnt_vld_c) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data_c;
                out_ch    <= gnt_idx_c;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer advances past the winner on unforced transfers only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load_c && gnt_vld_c && !force_en) begin
            ptr <= (gnt_idx_c == SELW'(NUM_CH - 1)) ? '0 : gnt_idx_c + SELW'(1);
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: queue-style sources, a cycle model of the arbiter
// checked every cycle, and directed scenarios with literal expectations.

module tb_rr_arb_mux;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    in_valid;
    logic [63:0]   in_data;
    logic [3:0]    in_ready;
    logic          force_en;
    logic [1:0]    force_sel;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic [1:0]    out_ch;

    logic [2:0]    in3_valid;
    logic [47:0]   in3_data;
    logic [2:0]    in3_ready;
    logic          force3_en;
    logic [1:0]    force3_sel;
    logic          out3_valid;
    logic          out3_ready;
    logic [15:0]   out3_data;
    logic [1:0]    out3_ch;

    int checks = 0;
    int errors = 0;

    int cnt [4];
    int seq [4];
    logic [3:0] tr_q = 4'b0;

    rr_arb_mux #(.DATAWIDTH(16), .NUM_CH(4), .SELW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .force_en(force_en), .force_sel(force_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch)
    );

    rr_arb_mux #(.DATAWIDTH(16), .NUM_CH(3), .SELW(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in3_valid), .in_data(in3_data), .in_ready(in3_ready),
        .force_en(force3_en), .force_sel(force3_sel),
        .out_valid(out3_valid), .out_ready(out3_ready),
        .out_data(out3_data), .out_ch(out3_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Sources: channel i presents word (0xA000 + i + seq*0x100) while it has words left.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i] = (cnt[i] > 0);
            in_data[i*DW +: DW] = 16'hA000 + 16'(i) + 16'(seq[i] << 8);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (tr_q[i]) begin
                cnt[i]--;
                seq[i]++;
            end
        end
        drive();
    endtask

    // ---------------- behavioural model ----------------
    int          m_ptr;
    bit          m_run;
    bit          m_ov;
    logic [15:0] m_od;
    int          m_oc;

    function automatic logic [15:0] word_of(input int c);
        return 16'(in_data >> (c * DW));
    endfunction

    function automatic int mgrant();
        if (force_en) begin
            if (int'(force_sel) < N && in_valid[force_sel]) return int'(force_sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[2'(c)]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_ov = 0; m_od = '0; m_oc = 0; m_ptr = 0;
        end else begin
            int g;
            bit ld;
            g  = mgrant();
            ld = m_run && (!m_ov || out_ready);
            if (ld) begin
                if (g >= 0) begin
                    m_od = word_of(g);
                    m_oc = g;
                    m_ov = 1;
                    if (!force_en) m_ptr = (g + 1) % N;
                end else begin
                    m_ov = 0;
                end
            end
            m_run = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [3:0]  p_v = 4'b0;
    logic [3:0]  p_r = 4'b0;
    logic [63:0] p_d = '0;

    always @(negedge clk) begin
        int g;
        bit ld;
        logic [3:0] er;
        g  = mgrant();
        ld = m_run && (!m_ov || out_ready);
        er = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("m_in_ready", 32'(in_ready), 32'(er));
        chk("m_out_valid", 32'(out_valid), 32'(m_ov));
        chk("m_out_data", 32'(out_data), 32'(m_od));
        chk("m_out_ch", 32'(out_ch), 32'(m_oc));
        for (int i = 0; i < N; i++) begin
            if (p_v[i] && !p_r[i]) begin
                chk("src_hold", {15'd0, in_valid[i], word_of(i)}, {15'd0, 1'b1, 16'(p_d >> (i * DW))});
            end
        end
        p_v  = in_valid;
        p_r  = in_ready;
        p_d  = in_data;
        tr_q = in_valid & in_ready;
    end

    // ---------------- directed stimulus ----------------
    int          exp_ch [11] = '{0, 1, 2, 3, 0, 1, 3, 1, 3, 1, 1};
    logic [15:0] exp_d  [11] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA100, 16'hA101,
                                 16'hA103, 16'hA201, 16'hA203, 16'hA301, 16'hA401};

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((cnt[0] + cnt[1] + cnt[2] + cnt[3]) > 0 && n < 60) begin
            step();
            n++;
        end
        chk(nm, 32'(cnt[0] + cnt[1] + cnt[2] + cnt[3]), 32'd0);
        step();
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        force_en  = 1'b0;
        force_sel = 2'd0;
        out_ready = 1'b1;
        cnt = '{2, 5, 1, 3};
        seq = '{0, 0, 0, 0};
        drive();
        in3_valid  = 3'b111;
        in3_data   = {16'h3002, 16'h3001, 16'h3000};
        force3_en  = 1'b1;
        force3_sel = 2'd3;
        out3_ready = 1'b1;

        // Reset with all channels valid.
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("start_ready0", 32'(in_ready), 32'd0);
        step();
        #1;
        chk("start_ready1", 32'(in_ready), 32'b0001);

        // Round-robin wrap followed by sparse requests on channels 1 and 3.
        for (int k = 0; k < 11; k++) begin
            step();
            chk("seq_ch", 32'(out_ch), 32'(exp_ch[k]));
            chk("seq_data", 32'(out_data), 32'(exp_d[k]));
        end
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Backpressure.
        cnt = '{4, 4, 4, 4};
        drive();
        step();
        chk("bp_first_ch", 32'(out_ch), 32'd2);
        chk("bp_first_data", 32'(out_data), 32'hA102);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk("bp_hold_data", 32'(out_data), 32'hA102);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_ch", 32'(out_ch), 32'd3);
        chk("bp_next_data", 32'(out_data), 32'hA303);

        // Forced select on channel 2 until it runs dry.
        force_en  = 1'b1;
        force_sel = 2'd2;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("force_ch", 32'(out_ch), 32'd2);
            chk("force_data", 32'(out_data), 32'(16'hA202 + 16'(k << 8)));
        end
        step();
        #1;
        chk("force_empty_valid", 32'(out_valid), 32'd0);
        chk("force_empty_ready", 32'(in_ready), 32'd0);
        force_en = 1'b0;
        step();
        chk("ptr_kept_ch", 32'(out_ch), 32'd0);
        chk("ptr_kept_data", 32'(out_data), 32'hA200);
        drain("drain1");

        // Reset while a word sits in the output register.
        cnt = '{2, 2, 2, 2};
        drive();
        step();
        step();
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_ch", 32'(out_ch), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("mid_ready0", 32'(in_ready), 32'd0);
        step();
        #1;
        chk("mid_ready1", 32'(in_ready), 32'b0001);
        step();
        chk("mid_restart_ch", 32'(out_ch), 32'd0);
        drain("drain2");

        // Three-channel instance: out-of-range force_sel grants nothing.
        chk("nc3_oor_valid", 32'(out3_valid), 32'd0);
        chk("nc3_oor_ready", 32'(in3_ready), 32'd0);
        force3_sel = 2'd1;
        #1;
        chk("nc3_f1_ready", 32'(in3_ready), 32'b010);
        step();
        chk("nc3_f1_valid", 32'(out3_valid), 32'd1);
        chk("nc3_f1_ch", 32'(out3_ch), 32'd1);
        chk("nc3_f1_data", 32'(out3_data), 32'h3001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised, registered N:1 bus multiplexer for the datapath-to-register-file write bus. It generalises the fixed 4:1 select mux to NUM_CH channels of DATAWIDTH bits. Each channel has a valid/ready handshake, and arbitration is round-robin, with a forced-select override that matches the old `cntrl` behaviour. The output is one pipeline register with its own valid/ready, so producers stall cleanly when the register-file port is busy.

## Interface
- DATAWIDTH, default `` `DATAWIDTH`` (16): width of each data word.
- NUM_CH, default 4: number of input channels, range 2..16; need not be a power of two.
- SELW, default 2: select width. Must satisfy 2**SELW >= NUM_CH.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  NUM_CH  bit i set: channel i presents a word.
- in_data  in  NUM_CH*DATAWIDTH  channel i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- in_ready  out  NUM_CH  one-hot or zero; bit i set: channel i's word is taken this cycle.
- force_en  in  1  when set, arbitration is replaced by force_sel.
- force_sel  in  SELW  channel forced when force_en=1.
- out_valid  out  1  out_data/out_ch hold a word.
- out_ready  in  1  downstream accepts the word this cycle.
- out_data  out  DATAWIDTH  registered selected word.
- out_ch  out  SELW  index of the channel that supplied out_data.

## Operation
Reset (rst_n=0), taking effect immediately:
- out_valid=0, out_data=0, out_ch=0.
- Round-robin pointer ptr=0.
- Internal run flag=0.

The run flag sets on the first clk edge after rst_n rises. in_ready is all-zero while run=0.

Load enable:
- load = run & (~out_valid | out_ready).

Grant, computed combinationally each cycle:
- If force_en=1: grant = force_sel when force_sel < NUM_CH and in_valid[force_sel]=1. Otherwise there is no grant; there is no fallback to other channels.
- If force_en=0: grant is the first i with in_valid[i]=1, scanning ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1 (wrap-around). There is no grant if in_valid is all-zero.

Handshake:
- in_ready[grant] = load. All other in_ready bits are 0.
- A transfer occurs on channel i when in_valid[i] & in_ready[i].
- in_valid must be held with stable in_data until the transfer. This is a source obligation; the bench asserts it.

On a clk edge with load=1:
- Grant exists: out_data <= in_data[grant], out_ch <= grant, out_valid <= 1.
- No grant: out_valid <= 0. out_data and out_ch hold their old values.

On a clk edge with load=0, all outputs hold.

Pointer:
- After a transfer with force_en=0: ptr <= (grant == NUM_CH-1) ? 0 : grant+1.
- Forced transfers and idle cycles leave ptr unchanged.

Simultaneous events:
- Output drain and new load in the same cycle are allowed. This gives full throughput of one word per cycle.
- force_en toggling mid-stream takes effect the same cycle. No state is flushed.
- Reset mid-transfer drops any word held in the output register. No in_ready is issued until run re-sets.

## Timing
- Latency: a word accepted on edge N appears on out_data/out_valid after edge N.
- Throughput: 1 word/cycle with out_ready held high.
- in_ready has a combinational path from in_valid, force_en, force_sel and out_ready. Sources must not make in_valid depend on in_ready.
- out_* are pure register outputs with no combinational path from inputs.
- Fairness: with all NUM_CH channels valid continuously and force_en=0, each channel is granted exactly once in every NUM_CH consecutive transfers.
- Backpressure: while out_valid=1 and out_ready=0, in_ready is all-zero and out_data is stable.

## Test plan
- Reset/startup: hold rst_n=0 with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0. After rst_n rises: in_ready=0 for the first cycle, then in_ready=4'b0001.
- Round-robin wrap: NUM_CH=4, all valid, out_ready=1, in_data = 0xA000+i → out_ch sequence 0,1,2,3,0,1 and out_data 0xA000, 0xA001, …, one word per cycle.
- Sparse requests: only channels 1 and 3 valid → grants alternate 1,3,1,3. Then drop channel 3 with ptr=2 → next grant is 1 (wrap).
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → out_data stable, in_ready=0, no source advances. out_ready=1 → next word loads on the same edge the old one drains.
- Forced select: force_en=1, force_sel=2, all valid → out_ch=2 on every transfer and ptr unchanged. With in_valid[2]=0 → out_valid falls to 0 and no other channel is granted. With NUM_CH=3 and force_sel=3 → no grant.
- Reset mid-stream: assert rst_n=0 while out_valid=1 → out_valid=0 and out_data=0 immediately, without waiting for a clock edge. After release, arbitration restarts at channel 0.
